s2_task_dispatch: RTL and testbench

Sequential consumer of the S2 feature-split descriptor (last_F, F21, F22, needMT64). It walks the two feature ranges in 32-feature chunks and issues one core task per cycle over a valid/ready stream. Range one is edge e_i over [last_F, F21-1]; range two is edge e_i+1 over [0, F22-1]. Cores are numbered 0..63 in issue order. It sits between the S2 split calculation and the per-core feature fetch units.

---
 rtl/s2_pkg.sv | 30 +++
 rtl/s2_chunk_len.sv | 18 +
 rtl/s2_task_dispatch.sv | 170 +++++++++++++++++
 tb/tb_s2_task_dispatch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/s2_pkg.sv
// Shared constants, FSM states and task word layout for the S2 task dispatcher.
package s2_pkg;

  localparam int TOTAL_F    = 3703;
  localparam int TOTAL_CORE = 64;
  localparam int F_PER_CORE = 32;

  localparam int F_W    = 12;
  localparam int CORE_W = 6;
  localparam int LEN_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    E1   = 2'd1,
    E2   = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [CORE_W-1:0] core;
    logic              edge_sel;
    logic [F_W-1:0]    f_start;
    logic [LEN_W-1:0]  f_len;
  } task_t;

  function automatic logic [F_W-1:0] clamp_f(input logic [F_W-1:0] f);
    return (f > F_W'(TOTAL_F)) ? F_W'(TOTAL_F) : f;
  endfunction

endpackage

// File: rtl/s2_chunk_len.sv
// Combinational chunk sizer: len = min(F_PER_CORE, range_end - cur) plus last-chunk flag.
module s2_chunk_len
  import s2_pkg::*;
(
  input  logic [F_W-1:0]   cur,
  input  logic [F_W-1:0]   range_end,
  output logic [LEN_W-1:0] len,
  output logic             last
);

  logic [F_W-1:0] remaining;

  // Remaining is compared at full width before being narrowed to a length.
  assign remaining = range_end - cur;
  assign last      = (remaining <= F_W'(F_PER_CORE));
  assign len       = last ? remaining[LEN_W-1:0] : LEN_W'(F_PER_CORE);

endmodule

// File: rtl/s2_task_dispatch.sv
// Walks the S2 split descriptor in 32-feature chunks and issues one core task per handshake.
// Optional S2_TASK_DISPATCH_STATS_EN adds saturating task/overflow counters.
module s2_task_dispatch
  import s2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [F_W-1:0]    desc_last_f,
  input  logic [F_W-1:0]    desc_f21,
  input  logic [F_W-1:0]    desc_f22,
  input  logic              desc_mt64,
  output logic              task_valid,
  input  logic              task_ready,
  output logic [CORE_W-1:0] task_core,
  output logic              task_edge,
  output logic [F_W-1:0]    task_f_start,
  output logic [LEN_W-1:0]  task_f_len,
  output logic              done,
  output logic              overflow,
  output logic              need_mt64
`ifdef S2_TASK_DISPATCH_STATS_EN
  ,
  output logic [15:0]       stat_tasks,
  output logic [15:0]       stat_overflows
`endif
);

  state_e            state_q, state_d;
  logic [F_W-1:0]    cur_q, cur_d;
  logic [CORE_W-1:0] core_q, core_d;
  logic [F_W-1:0]    f21_q, f21_d;
  logic [F_W-1:0]    f22_q, f22_d;
  logic              ovf_q, ovf_d;
  logic              mt64_q, mt64_d;
  logic              ovf_event;
  logic              handshake;

  logic [F_W-1:0]    range_end;
  logic [LEN_W-1:0]  chunk_len;
  logic              chunk_last;
  logic [F_W-1:0]    f21_clamped;
  logic [F_W-1:0]    f22_clamped;
  task_t             tword;

  assign range_end   = (state_q == E2) ? f22_q : f21_q;
  assign f21_clamped = clamp_f(desc_f21);
  assign f22_clamped = clamp_f(desc_f22);

  s2_chunk_len u_chunk_len (
    .cur       (cur_q),
    .range_end (range_end),
    .len       (chunk_len),
    .last      (chunk_last)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    core_d     = core_q;
    f21_d      = f21_q;
    f22_d      = f22_q;
    ovf_d      = ovf_q;
    mt64_d     = mt64_q;
    ovf_event  = 1'b0;
    desc_ready = 1'b0;
    task_valid = 1'b0;
    done       = 1'b0;
    tword      = '0;
    case (state_q)
      IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          f21_d  = f21_clamped;
          f22_d  = f22_clamped;
          cur_d  = desc_last_f;
          core_d = '0;
          ovf_d  = 1'b0;
          mt64_d = desc_mt64;
          if (f21_clamped > desc_last_f) begin
            state_d = E1;
          end else if (f22_clamped != '0) begin
            state_d = E2;
            cur_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      E1, E2: begin
        task_valid     = 1'b1;
        tword.core     = core_q;
        tword.edge_sel = (state_q == E2);
        tword.f_start  = cur_q;
        tword.f_len    = chunk_len;
        if (task_ready) begin
          cur_d  = cur_q + F_W'(chunk_len);
          core_d = core_q + 1'b1;
          // Finishing the last range wins over core exhaustion; anything left is overflow.
          if (chunk_last && (state_q == E2 || f22_q == '0)) begin
            state_d = DONE;
          end else if (core_q == CORE_W'(TOTAL_CORE - 1)) begin
            ovf_d     = 1'b1;
            ovf_event = 1'b1;
            state_d   = DONE;
          end else if (chunk_last) begin
            state_d = E2;
            cur_d   = '0;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign handshake    = task_valid && task_ready;
  assign task_core    = tword.core;
  assign task_edge    = tword.edge_sel;
  assign task_f_start = tword.f_start;
  assign task_f_len   = tword.f_len;
  assign overflow     = ovf_q;
  assign need_mt64    = mt64_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      core_q  <= '0;
      ovf_q   <= 1'b0;
      mt64_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      core_q  <= core_d;
      ovf_q   <= ovf_d;
      mt64_q  <= mt64_d;
    end
  end

  // Range bounds are only read outside IDLE, after an accept has loaded them.
  always_ff @(posedge clk) begin
    f21_q <= f21_d;
    f22_q <= f22_d;
  end

`ifdef S2_TASK_DISPATCH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_tasks     <= '0;
      stat_overflows <= '0;
    end else begin
      if (handshake) stat_tasks <= sat_inc(stat_tasks);
      if (ovf_event) stat_overflows <= sat_inc(stat_overflows);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = handshake ^ ovf_event;
`endif

endmodule

// File: tb/tb_s2_task_dispatch.sv
// Directed bench for s2_task_dispatch: descriptor walks, overflow, clamping, stalls and reset.
module tb_s2_task_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        desc_valid;
  logic        desc_ready;
  logic [11:0] desc_last_f;
  logic [11:0] desc_f21;
  logic [11:0] desc_f22;
  logic        desc_mt64;
  logic        task_valid;
  logic        task_ready;
  logic [5:0]  task_core;
  logic        task_edge;
  logic [11:0] task_f_start;
  logic [5:0]  task_f_len;
  logic        done;
  logic        overflow;
  logic        need_mt64;

  always #5 clk = ~clk;

  s2_task_dispatch dut (
    .clk          (clk),
    .rst          (rst),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_last_f  (desc_last_f),
    .desc_f21     (desc_f21),
    .desc_f22     (desc_f22),
    .desc_mt64    (desc_mt64),
    .task_valid   (task_valid),
    .task_ready   (task_ready),
    .task_core    (task_core),
    .task_edge    (task_edge),
    .task_f_start (task_f_start),
    .task_f_len   (task_f_len),
    .done         (done),
    .overflow     (overflow),
    .need_mt64    (need_mt64)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int n;
  int done_cyc;
  int ovf_done, mt_done, rdy_after, ovf_after, done_after;
  int oc[128], oe[128], os[128], ol[128];
  int st_valid[4], st_start[4];

  // Accepts one descriptor, then records every handshaken task until done.
  task automatic run_desc(input int lf, input int f21, input int f22, input int mt,
                          input int stall_at, input int stall_n);
    int left;
    int ns;
    bit got;
    left = stall_n;
    ns   = 0;
    got  = 1'b0;
    n    = 0;
    done_cyc = -1;
    @(negedge clk);
    desc_last_f = lf[11:0];
    desc_f21    = f21[11:0];
    desc_f22    = f22[11:0];
    desc_mt64   = mt[0];
    desc_valid  = 1'b1;
    task_ready  = 1'b1;
    chk("accept_ready", desc_ready, 1);
    @(posedge clk);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      desc_valid = 1'b0;
      if (done) begin
        done_cyc = k;
        ovf_done = overflow;
        mt_done  = need_mt64;
        @(negedge clk);
        rdy_after  = desc_ready;
        ovf_after  = overflow;
        done_after = done;
        got = 1'b1;
        break;
      end
      if (n == stall_at && left > 0) begin
        task_ready = 1'b0;
        if (ns < 4) begin
          st_valid[ns] = task_valid;
          st_start[ns] = task_f_start;
          ns++;
        end
        left--;
      end else begin
        task_ready = 1'b1;
        if (task_valid && n < 128) begin
          oc[n] = task_core;
          oe[n] = task_edge;
          os[n] = task_f_start;
          ol[n] = task_f_len;
          n++;
        end
      end
    end
    task_ready = 1'b1;
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    desc_valid  = 1'b0;
    desc_last_f = '0;
    desc_f21    = '0;
    desc_f22    = '0;
    desc_mt64   = 1'b0;
    task_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_task_valid", task_valid, 0);
    chk("rst_task_core", task_core, 0);
    chk("rst_f_start", task_f_start, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_need_mt64", need_mt64, 0);

    // Split across both edges, fills exactly 64 cores.
    run_desc(3680, 3703, 2016, 0, -1, 0);
    chk("t1_count", n, 64);
    chk("t1_c0_core", oc[0], 0);
    chk("t1_c0_edge", oe[0], 0);
    chk("t1_c0_start", os[0], 3680);
    chk("t1_c0_len", ol[0], 23);
    for (int i = 1; i < 64; i++) begin
      chk("t1_core", oc[i], i);
      chk("t1_edge", oe[i], 1);
      chk("t1_start", os[i], (i - 1) * 32);
      chk("t1_len", ol[i], 32);
    end
    chk("t1_done_cyc", done_cyc, 65);
    chk("t1_overflow", ovf_done, 0);
    chk("t1_mt64", mt_done, 0);
    chk("t1_ready_after", rdy_after, 1);
    chk("t1_done_pulse", done_after, 0);

    // First range alone exhausts all cores.
    run_desc(0, 3703, 100, 1, -1, 0);
    chk("t2_count", n, 64);
    for (int i = 0; i < 64; i++) begin
      chk("t2_core", oc[i], i);
      chk("t2_edge", oe[i], 0);
      chk("t2_start", os[i], i * 32);
      chk("t2_len", ol[i], 32);
    end
    chk("t2_done_cyc", done_cyc, 65);
    chk("t2_overflow", ovf_done, 1);
    chk("t2_mt64", mt_done, 1);
    chk("t2_overflow_held", ovf_after, 1);

    // Both ranges empty.
    run_desc(500, 500, 0, 0, -1, 0);
    chk("t3_count", n, 0);
    chk("t3_done_cyc", done_cyc, 1);
    chk("t3_ready_after", rdy_after, 1);
    chk("t3_overflow_cleared", ovf_done, 0);
    chk("t3_mt64_cleared", mt_done, 0);

    // Out-of-range f21/f22 are clamped to TOTAL_F.
    run_desc(3690, 4000, 4000, 1, -1, 0);
    chk("t4_count", n, 64);
    chk("t4_c0_start", os[0], 3690);
    chk("t4_c0_len", ol[0], 13);
    chk("t4_c0_edge", oe[0], 0);
    chk("t4_c1_edge", oe[1], 1);
    chk("t4_c1_start", os[1], 0);
    chk("t4_c63_core", oc[63], 63);
    chk("t4_c63_start", os[63], 1984);
    chk("t4_c63_len", ol[63], 32);
    chk("t4_overflow", ovf_done, 1);
    chk("t4_mt64", mt_done, 1);

    // Three-cycle stall while task 3 (e1 start 64) is presented.
    run_desc(3680, 3703, 200, 0, 3, 3);
    chk("t5_count", n, 8);
    chk("t5_c0_start", os[0], 3680);
    for (int i = 1; i < 8; i++) begin
      chk("t5_core", oc[i], i);
      chk("t5_edge", oe[i], 1);
      chk("t5_start", os[i], (i - 1) * 32);
      chk("t5_len", ol[i], (i == 7) ? 8 : 32);
    end
    for (int j = 0; j < 3; j++) begin
      chk("t5_stall_valid", st_valid[j], 1);
      chk("t5_stall_start", st_start[j], 64);
    end
    chk("t5_done_cyc", done_cyc, 12);
    chk("t5_overflow", ovf_done, 0);

    // Reset in the middle of a dispatch.
    @(negedge clk);
    desc_last_f = 12'd0;
    desc_f21    = 12'd3703;
    desc_f22    = 12'd100;
    desc_mt64   = 1'b1;
    desc_valid  = 1'b1;
    task_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    desc_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_pre_rst_core", task_core, 10);
    chk("t6_pre_rst_start", task_f_start, 320);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_task_valid", task_valid, 0);
    chk("t6_task_core", task_core, 0);
    chk("t6_task_edge", task_edge, 0);
    chk("t6_f_start", task_f_start, 0);
    chk("t6_f_len", task_f_len, 0);
    chk("t6_done", done, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_need_mt64", need_mt64, 0);
    chk("t6_desc_ready", desc_ready, 1);
    rst = 1'b0;

    run_desc(0, 40, 10, 0, -1, 0);
    chk("t7_count", n, 3);
    chk("t7_c0_core", oc[0], 0);
    chk("t7_c0_start", os[0], 0);
    chk("t7_c0_len", ol[0], 32);
    chk("t7_c1_start", os[1], 32);
    chk("t7_c1_len", ol[1], 8);
    chk("t7_c2_core", oc[2], 2);
    chk("t7_c2_edge", oe[2], 1);
    chk("t7_c2_len", ol[2], 10);
    chk("t7_done_cyc", done_cyc, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
